// File: rtl/ctrl_types_pkg.sv
// rtl/ctrl_types_pkg.sv - shared types for the cache operation controller
//
// Purpose: opcode, sub-unit response, top-level state, response status and
// per-operation substate encodings shared by the sequencer and its helpers.
package ctrl_types_pkg;

  typedef enum logic [2:0] {
    OP_NOOP   = 3'd0,
    OP_READ   = 3'd1,
    OP_UPSERT = 3'd2,
    OP_DELETE = 3'd3
  } operation_e;

  // Sub-unit handshake: {done, error}
  typedef struct packed {
    logic done;
    logic error;
  } sub_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GET    = 3'd1,
    ST_UPSERT = 3'd2,
    ST_DEL    = 3'd3,
    ST_ERR    = 3'd4,
    ST_RESP   = 3'd5
  } top_state_e;

  typedef enum logic [1:0] {
    STAT_OK      = 2'd0,
    STAT_FAIL    = 2'd1,
    STAT_TIMEOUT = 2'd2,
    STAT_ILLEGAL = 2'd3
  } status_e;

  typedef enum logic {
    SUB_START = 1'b0,
    SUB_WAIT  = 1'b1
  } op_substate_e;

  function automatic logic is_op_state(top_state_e s);
    return (s == ST_GET) || (s == ST_UPSERT) || (s == ST_DEL);
  endfunction

endpackage

// File: rtl/op_attempt_timer.sv
// rtl/op_attempt_timer.sv - per-attempt timeout counter and retry counter
//
// Purpose: counts WAIT cycles of the current attempt and the number of retries
// already spent on the current command.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   tmo_clr_i       clear the WAIT-cycle counter (attempt start)
//   tmo_inc_i       count one idle WAIT cycle
//   retry_clr_i     clear the retry counter (command accept)
//   retry_inc_i     consume one retry
//   tmo_expired_o   current WAIT cycle is the TIMEOUT-th one
//   retry_avail_o   another retry is still permitted
module op_attempt_timer #(
  parameter int TIMEOUT   = 255,
  parameter int RETRY_MAX = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tmo_clr_i,
  input  logic tmo_inc_i,
  input  logic retry_clr_i,
  input  logic retry_inc_i,
  output logic tmo_expired_o,
  output logic retry_avail_o
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  // +2 keeps the width non-zero when RETRY_MAX is 0
  localparam int RW = $clog2(RETRY_MAX + 2);

  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] retry_q, retry_d;

  // The counter holds the number of WAIT cycles already completed, so the
  // cycle in which it reads TIMEOUT-1 is the last one allowed.
  assign tmo_expired_o = (tmo_q == TW'(TIMEOUT - 1));
  assign retry_avail_o = (retry_q < RW'(RETRY_MAX));

  always_comb begin
    tmo_d = tmo_q;
    if (tmo_clr_i) begin
      tmo_d = '0;
    end else if (tmo_inc_i && !tmo_expired_o) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_comb begin
    retry_d = retry_q;
    if (retry_clr_i) begin
      retry_d = '0;
    end else if (retry_inc_i && retry_avail_o) begin
      retry_d = retry_q + RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_q   <= '0;
      retry_q <= '0;
    end else begin
      tmo_q   <= tmo_d;
      retry_q <= retry_d;
    end
  end

endmodule

// File: rtl/cache_op_sequencer.sv
// rtl/cache_op_sequencer.sv - top-level cache operation controller
//
// Purpose: accepts one command, dispatches it to the GET/UPSERT/DEL unit with
// bounded retry and per-attempt timeout, and returns one held response.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_op/cmd_key/cmd_val          opcode (4..7 illegal), key, upsert value
//   sub_key/sub_val                 latched key/value to sub-units
//   get_start/upsert_start/del_start one-cycle start pulse per attempt
//   get_rsp/upsert_rsp/del_rsp      {done,error} from each unit
//   get_data                        read data, valid with get_rsp.done
//   rsp_valid/rsp_ready             response handshake
//   rsp_status/rsp_data             status_e and read data
//   state_o                         current top_state_e (debug)
module cache_op_sequencer
  import ctrl_types_pkg::*;
#(
  parameter int KEY_W     = 16,
  parameter int VAL_W     = 32,
  parameter int TIMEOUT   = 255,
  parameter int RETRY_MAX = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [KEY_W-1:0] cmd_key,
  input  logic [VAL_W-1:0] cmd_val,
  output logic [KEY_W-1:0] sub_key,
  output logic [VAL_W-1:0] sub_val,
  output logic             get_start,
  output logic             upsert_start,
  output logic             del_start,
  input  logic [1:0]       get_rsp,
  input  logic [VAL_W-1:0] get_data,
  input  logic [1:0]       upsert_rsp,
  input  logic [1:0]       del_rsp,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_status,
  output logic [VAL_W-1:0] rsp_data,
  output logic [2:0]       state_o
);

  top_state_e       state_q, state_d;
  op_substate_e     sub_q, sub_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [VAL_W-1:0] val_q, val_d;
  status_e          status_q, status_d;
  logic [VAL_W-1:0] data_q, data_d;

  logic     tmo_clr, tmo_inc, retry_clr, retry_inc;
  logic     tmo_expired, retry_avail;
  sub_cmd_t act_rsp;

  op_attempt_timer #(
    .TIMEOUT  (TIMEOUT),
    .RETRY_MAX(RETRY_MAX)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .tmo_clr_i    (tmo_clr),
    .tmo_inc_i    (tmo_inc),
    .retry_clr_i  (retry_clr),
    .retry_inc_i  (retry_inc),
    .tmo_expired_o(tmo_expired),
    .retry_avail_o(retry_avail)
  );

  // Only the unit owning the current state is listened to.
  always_comb begin
    act_rsp = '0;
    case (state_q)
      ST_GET:    act_rsp = sub_cmd_t'(get_rsp);
      ST_UPSERT: act_rsp = sub_cmd_t'(upsert_rsp);
      ST_DEL:    act_rsp = sub_cmd_t'(del_rsp);
      default:   act_rsp = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    sub_d     = sub_q;
    key_d     = key_q;
    val_d     = val_q;
    status_d  = status_q;
    data_d    = data_q;
    tmo_clr   = 1'b0;
    tmo_inc   = 1'b0;
    retry_clr = 1'b0;
    retry_inc = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          key_d     = cmd_key;
          val_d     = cmd_val;
          status_d  = STAT_OK;
          data_d    = '0;
          retry_clr = 1'b1;
          sub_d     = SUB_START;
          case (cmd_op)
            OP_NOOP:   state_d = ST_RESP;
            OP_READ:   state_d = ST_GET;
            OP_UPSERT: state_d = ST_UPSERT;
            OP_DELETE: state_d = ST_DEL;
            default: begin
              state_d  = ST_ERR;
              status_d = STAT_ILLEGAL;
            end
          endcase
        end
      end

      ST_GET, ST_UPSERT, ST_DEL: begin
        if (sub_q == SUB_START) begin
          tmo_clr = 1'b1;
          sub_d   = SUB_WAIT;
        end else if (act_rsp.error) begin
          // error outranks a simultaneous done
          if (retry_avail) begin
            retry_inc = 1'b1;
            sub_d     = SUB_START;
          end else begin
            state_d  = ST_ERR;
            status_d = STAT_FAIL;
          end
        end else if (act_rsp.done) begin
          state_d  = ST_RESP;
          status_d = STAT_OK;
          if (state_q == ST_GET) begin
            data_d = get_data;
          end
        end else if (tmo_expired) begin
          state_d  = ST_ERR;
          status_d = STAT_TIMEOUT;
        end else begin
          tmo_inc = 1'b1;
        end
      end

      ST_ERR: begin
        data_d  = '0;
        state_d = ST_RESP;
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sub_q    <= SUB_START;
      key_q    <= '0;
      val_q    <= '0;
      status_q <= STAT_OK;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      sub_q    <= sub_d;
      key_q    <= key_d;
      val_q    <= val_d;
      status_q <= status_d;
      data_q   <= data_d;
    end
  end

  assign cmd_ready    = (state_q == ST_IDLE);
  assign get_start    = (state_q == ST_GET)    && (sub_q == SUB_START);
  assign upsert_start = (state_q == ST_UPSERT) && (sub_q == SUB_START);
  assign del_start    = (state_q == ST_DEL)    && (sub_q == SUB_START);
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_status   = status_q;
  assign rsp_data     = data_q;
  assign sub_key      = key_q;
  assign sub_val      = val_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_cache_op_sequencer.sv
// tb/tb_cache_op_sequencer.sv - self-checking bench for cache_op_sequencer
module tb_cache_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_key;
  logic [31:0] cmd_val;
  logic [15:0] sub_key;
  logic [31:0] sub_val;
  logic        get_start, upsert_start, del_start;
  logic [1:0]  get_rsp, upsert_rsp, del_rsp;
  logic [31:0] get_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_data;
  logic [2:0]  state_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_op_sequencer #(
    .KEY_W(16), .VAL_W(32), .TIMEOUT(8), .RETRY_MAX(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_key(cmd_key), .cmd_val(cmd_val),
    .sub_key(sub_key), .sub_val(sub_val),
    .get_start(get_start), .upsert_start(upsert_start), .del_start(del_start),
    .get_rsp(get_rsp), .get_data(get_data),
    .upsert_rsp(upsert_rsp), .del_rsp(del_rsp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_data(rsp_data),
    .state_o(state_o)
  );

  typedef struct {
    logic [2:0]  op;
    logic [15:0] key;
    logic [31:0] val;
    logic [31:0] rdata;
    int          n_err;      // attempts answered with error before done
    int          wait_n;     // WAIT cycle of the unit's answer, 0 = never
    bit          err_done;   // error attempts also raise done
    bit          noise;      // other units assert done|error every cycle
    int          hold;       // cycles rsp_ready stays low once valid
    logic [1:0]  exp_status;
    logic [31:0] exp_data;
    int          exp_starts;
    int          exp_lat;    // cycle of rsp_valid, accept cycle = 0
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic [2:0] op, logic [15:0] key, logic [31:0] val,
                              logic [31:0] rdata, int n_err, int wait_n, bit err_done,
                              bit noise, int hold, logic [1:0] st, logic [31:0] d,
                              int starts, int lat);
    vec_t v;
    v.op = op; v.key = key; v.val = val; v.rdata = rdata;
    v.n_err = n_err; v.wait_n = wait_n; v.err_done = err_done; v.noise = noise;
    v.hold = hold; v.exp_status = st; v.exp_data = d;
    v.exp_starts = starts; v.exp_lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_unit(input logic [2:0] op, input logic [1:0] r);
    case (op)
      3'd1:    get_rsp    = r;
      3'd2:    upsert_rsp = r;
      3'd3:    del_rsp    = r;
      default: ;
    endcase
  endtask

  task automatic clear_rsp();
    get_rsp = 2'b00; upsert_rsp = 2'b00; del_rsp = 2'b00; get_data = '0;
  endtask

  function automatic int n_starts();
    return int'(get_start) + int'(upsert_start) + int'(del_start);
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int  lat, starts, wrong, attempt, widx, held_bad;
    bit  armed, found, key_seen, own;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = v.op; cmd_key = v.key; cmd_val = v.val;
    rsp_ready = (v.hold == 0);
    @(negedge clk);
    chk($sformatf("v%0d_cmd_ready", idx), cmd_ready, 1);
    lat = -1; starts = 0; wrong = 0; attempt = 0; widx = 0;
    armed = 0; found = 0; key_seen = 0;
    for (int cyc = 1; cyc <= 40 && !found; cyc++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      clear_rsp();
      if (v.noise) begin
        if (v.op != 3'd1) get_rsp    = 2'b11;
        if (v.op != 3'd2) upsert_rsp = 2'b11;
        if (v.op != 3'd3) del_rsp    = 2'b11;
      end
      if (armed) begin
        widx++;
        if (widx == v.wait_n) begin
          armed = 0;
          if (attempt <= v.n_err) begin
            drive_unit(v.op, v.err_done ? 2'b11 : 2'b01);
            get_data = ~v.rdata;
          end else begin
            drive_unit(v.op, 2'b10);
            get_data = v.rdata;
          end
        end
      end
      @(negedge clk);
      if (n_starts() > 0) begin
        starts += n_starts();
        own = (v.op == 3'd1 && get_start) || (v.op == 3'd2 && upsert_start) ||
              (v.op == 3'd3 && del_start);
        if (own) begin
          attempt++; widx = 0; armed = (v.wait_n > 0);
          if (!key_seen) begin
            key_seen = 1;
            chk($sformatf("v%0d_sub_keyval", idx), {sub_key, sub_val}, {v.key, v.val});
          end
        end else begin
          wrong++;
        end
      end
      if (rsp_valid) begin
        found = 1; lat = cyc;
      end
    end
    chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d_status", idx), rsp_status, v.exp_status);
    chk($sformatf("v%0d_data", idx), rsp_data, v.exp_data);
    chk($sformatf("v%0d_starts", idx), starts, v.exp_starts);
    chk($sformatf("v%0d_wrong_unit_starts", idx), wrong, 0);
    if (v.hold > 0) begin
      held_bad = 0;
      for (int h = 0; h < v.hold; h++) begin
        @(posedge clk); #1;
        clear_rsp();
        cmd_valid = 1'b1; cmd_op = 3'd1; get_rsp = 2'b10; get_data = 32'h1234_5678;
        @(negedge clk);
        if (!(rsp_valid && rsp_status == v.exp_status && rsp_data == v.exp_data &&
              !cmd_ready && n_starts() == 0))
          held_bad++;
      end
      chk($sformatf("v%0d_held_cycles_bad", idx), held_bad, 0);
      rsp_ready = 1'b1;
    end
    // handshake edge, then one idle cycle: back in IDLE, nothing launched
    @(posedge clk); #1;
    cmd_valid = 1'b0; clear_rsp();
    @(negedge clk);
    chk($sformatf("v%0d_after_hs", idx), {rsp_valid, cmd_ready, state_o}, {1'b0, 1'b1, 3'd0});
    @(posedge clk); #1;
    @(negedge clk);
    chk($sformatf("v%0d_no_extra_start", idx), n_starts(), 0);
    if (!found) begin
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
    end
  endtask

  initial begin
    int bad;
    //                 op    key      val           rdata        ne wn ed nz hold st    data         s  lat
    vecs[0]  = mk(3'd1, 16'h0012, 32'h0,        32'hDEADBEEF, 0, 3, 0, 0, 0,  2'd0, 32'hDEADBEEF, 1, 5);
    vecs[1]  = mk(3'd2, 16'h0034, 32'h1111_2222, 32'h0,       2, 1, 0, 0, 0,  2'd0, 32'h0,        3, 7);
    vecs[2]  = mk(3'd2, 16'h0035, 32'h3333_4444, 32'h0,       3, 1, 0, 0, 0,  2'd1, 32'h0,        3, 8);
    vecs[3]  = mk(3'd3, 16'h0056, 32'h0,        32'h0,        0, 0, 0, 1, 0,  2'd2, 32'h0,        1, 11);
    vecs[4]  = mk(3'd5, 16'h0099, 32'hAAAA_5555, 32'h0,       0, 0, 0, 0, 0,  2'd3, 32'h0,        0, 2);
    vecs[5]  = mk(3'd0, 16'h0001, 32'h0,        32'h0,        0, 0, 0, 0, 0,  2'd0, 32'h0,        0, 1);
    vecs[6]  = mk(3'd1, 16'h00A1, 32'h0,        32'h0BADF00D, 1, 2, 1, 0, 0,  2'd0, 32'h0BADF00D, 2, 7);
    vecs[7]  = mk(3'd1, 16'h00A2, 32'h0,        32'h87654321, 0, 8, 0, 0, 0,  2'd0, 32'h87654321, 1, 10);
    vecs[8]  = mk(3'd3, 16'h00B3, 32'h0,        32'h0,        0, 1, 0, 0, 0,  2'd0, 32'h0,        1, 3);
    vecs[9]  = mk(3'd1, 16'h00C4, 32'h0,        32'h1357_9BDF, 3, 1, 0, 0, 0, 2'd1, 32'h0,        3, 8);
    vecs[10] = mk(3'd1, 16'h00D5, 32'h0,        32'hCAFEF00D, 0, 1, 0, 0, 10, 2'd0, 32'hCAFEF00D, 1, 3);
    vecs[11] = mk(3'd7, 16'h00E6, 32'h0,        32'h0,        0, 0, 0, 0, 0,  2'd3, 32'h0,        0, 2);

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_key = '0; cmd_val = '0;
    rsp_ready = 1'b1; clear_rsp();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", state_o, 3'd0);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_starts", n_starts(), 0);
    chk("reset_status_data", {rsp_status, rsp_data}, 34'h0);
    chk("reset_sub_keyval", {sub_key, sub_val}, 48'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // reset while the GET unit is being waited on
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_key = 16'h0077; cmd_val = 32'h0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_start_seen", get_start, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_in_wait", state_o, 3'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    get_rsp = 2'b10; get_data = 32'h5555_AAAA;
    @(negedge clk);
    chk("rst_mid_idle", {state_o, rsp_valid, cmd_ready, n_starts() != 0}, {3'd0, 1'b0, 1'b1, 1'b0});
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (rsp_valid || n_starts() != 0 || state_o != 3'd0) bad++;
    end
    chk("rst_mid_late_done_ignored", bad, 0);
    clear_rsp();

    // the controller is usable again after the mid-op reset
    run_vec(12, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule
